seven_seg_scan: RTL and testbench

- Downstream consumer of the four-character ASCII scroller outputs.
- Snapshots four ASCII codes once per scan and decodes each to a 7-segment pattern.
- Time-multiplexes the Basys2 4-digit common-anode display (active-low anodes and cathodes).
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seven_seg_scan.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit ASCII 7-segment scanner with inter-digit blanking (optional SEG_BRIGHTNESS_EN)
module seven_seg_scan #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] asciiOne,
  input  logic [7:0] asciiTwo,
  input  logic [7:0] asciiThree,
  input  logic [7:0] asciiFour,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       scanStart
);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [1:0]  index_q;
  logic [7:0]  sh_one_q, sh_two_q, sh_three_q, sh_four_q;
  logic [3:0]  an_q;
  logic [7:0]  seg_q;
  logic        scan_start_q;

  logic [3:0]  drive_an;
  logic [7:0]  drive_char;
  logic [7:0]  drive_seg;
  logic        drive_on;

`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]  br_q;
  logic [35:0] on_limit;
`endif

  // ASCII to active-low {dp,g,f,e,d,c,b,a}; anything unknown is blank
  function automatic logic [7:0] decode(input logic [7:0] c);
    logic [7:0] s;
    case (c)
      8'h30: s = 8'hC0;
      8'h31: s = 8'hF9;
      8'h32: s = 8'hA4;
      8'h33: s = 8'hB0;
      8'h34: s = 8'h99;
      8'h35: s = 8'h92;
      8'h36: s = 8'h82;
      8'h37: s = 8'hF8;
      8'h38: s = 8'h80;
      8'h39: s = 8'h90;
      8'h41, 8'h61: s = 8'h88;
      8'h42, 8'h62: s = 8'h83;
      8'h43: s = 8'hC6;
      8'h63: s = 8'hA7;
      8'h44, 8'h64: s = 8'hA1;
      8'h45, 8'h65: s = 8'h86;
      8'h46, 8'h66: s = 8'h8E;
      8'h2D: s = 8'hBF;
      8'h5F: s = 8'hF7;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Select anode and shadowed character for the current slot; gate by duty window
  always_comb begin
    drive_an   = 4'hF;
    drive_char = 8'hFF;
    cnt_d      = cnt_q + 32'd1;
    case (index_q)
      2'd0: begin drive_an = 4'b0111; drive_char = sh_one_q;   end
      2'd1: begin drive_an = 4'b1011; drive_char = sh_two_q;   end
      2'd2: begin drive_an = 4'b1101; drive_char = sh_three_q; end
      default: begin drive_an = 4'b1110; drive_char = sh_four_q; end
    endcase
    drive_seg = decode(drive_char);
`ifdef SEG_BRIGHTNESS_EN
    on_limit = ((36'(br_q) + 36'd1) * 36'(DIGIT_CYCLES)) >> 4;
    drive_on = ({4'd0, cnt_q} < on_limit);
`else
    drive_on = 1'b1;
`endif
  end

  // Scan FSM: blank gap, then drive one digit; snapshot inputs at the start of each scan
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_BLANK;
      cnt_q        <= 32'd0;
      index_q      <= 2'd0;
      sh_one_q     <= 8'hFF;
      sh_two_q     <= 8'hFF;
      sh_three_q   <= 8'hFF;
      sh_four_q    <= 8'hFF;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      scan_start_q <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      br_q         <= 4'hF;
`endif
    end else begin
      scan_start_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == 32'd0 && index_q == 2'd0) begin
            sh_one_q     <= asciiOne;
            sh_two_q     <= asciiTwo;
            sh_three_q   <= asciiThree;
            sh_four_q    <= asciiFour;
            scan_start_q <= 1'b1;
`ifdef SEG_BRIGHTNESS_EN
            br_q         <= brightness;
`endif
          end
          if (cnt_q >= BLANK_CYCLES - 32'd1) begin
            state_q <= ST_DRIVE;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DRIVE: begin
          if (drive_on) begin
            an_q  <= drive_an;
            seg_q <= drive_seg;
          end
          if (cnt_q >= DIGIT_CYCLES - 32'd1) begin
            state_q <= ST_BLANK;
            cnt_q   <= 32'd0;
            index_q <= index_q + 2'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= 32'd0;
        end
      endcase
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign scanStart = scan_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed table-driven bench for seven_seg_scan
module tb_seven_seg_scan;

`ifdef SEG_BRIGHTNESS_EN
  localparam int DC = 16;
`else
  localparam int DC = 4;
`endif
  localparam int BC  = 2;
  localparam int SL  = BC + DC;
  localparam int PER = 4 * SL;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] asciiOne, asciiTwo, asciiThree, asciiFour;
  logic [3:0] an;
  logic [7:0] seg;
  logic       scanStart;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0] brightness = 4'hF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] chars;
    logic [31:0] segs;
  } vec_t;
  vec_t vecs[5];

  seven_seg_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .asciiOne(asciiOne),
    .asciiTwo(asciiTwo),
    .asciiThree(asciiThree),
    .asciiFour(asciiFour),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .an(an),
    .seg(seg),
    .scanStart(scanStart)
  );

  always #5 CLK = ~CLK;

  task automatic set_chars(input logic [31:0] c);
    asciiOne   = c[31:24];
    asciiTwo   = c[23:16];
    asciiThree = c[15:8];
    asciiFour  = c[7:0];
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: an/seg/scanStart got %h/%h/%b expected %h/%h/%b",
               name, act[12:9], act[8:1], act[0], exp[12:9], exp[8:1], exp[0]);
    end
  endtask

  // Walk one scan starting at the capture edge; optionally change inputs or stop early.
  task automatic do_scan(input logic [31:0] segs, input int chg_k, input logic [31:0] chg_val,
                         input int stop_k, input int thr);
    logic [3:0] e_an;
    logic [7:0] e_seg;
    int r, s, p;
    for (int k = 0; k < PER; k++) begin
      @(posedge CLK);
      #1;
      e_an  = 4'hF;
      e_seg = 8'hFF;
      if (k >= BC) begin
        r = k - BC;
        s = r / SL;
        p = r % SL;
        if (p < DC && p < thr) begin
          e_an  = ~(4'b1000 >> s);
          e_seg = segs[31 - 8*s -: 8];
        end
      end
      check($sformatf("scan k=%0d", k), {an, seg, scanStart}, {e_an, e_seg, (k == 0)});
      if (k == chg_k) set_chars(chg_val);
      if (k == stop_k) return;
    end
  endtask

  initial begin
    vecs[0] = '{chars: "12AF", segs: 32'hF9A4888E};
    vecs[1] = '{chars: {"Z", 8'hFF, "-", "b"}, segs: 32'hFFFFBF83};
    vecs[2] = '{chars: "0789", segs: 32'hC0F88090};
    vecs[3] = '{chars: "cCdE", segs: 32'hA7C6A186};
    vecs[4] = '{chars: " _3a", segs: 32'hFFF7B088};

    // Reset hold with arbitrary inputs
    set_chars("8888");
    RESET_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("reset hold %0d", i), {an, seg, scanStart}, {4'hF, 8'hFF, 1'b0});
    end

    // Table of full scans, back to back
    for (int v = 0; v < 5; v++) begin
      set_chars(vecs[v].chars);
      RESET_N = 1'b1;
      do_scan(vecs[v].segs, -1, 32'd0, -1, DC);
    end

    // Snapshot isolation: change during index-1 drive
    set_chars("12AF");
    do_scan(32'hF9A4888E, BC + SL + 1, "9999", -1, DC);
    do_scan(32'h90909090, -1, 32'd0, -1, DC);

    // Reset in the middle of the index-2 drive
    set_chars("12AF");
    do_scan(32'hF9A4888E, -1, 32'd0, BC + 2*SL + 1, DC);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    check("mid reset edge", {an, seg, scanStart}, {4'hF, 8'hFF, 1'b0});
    set_chars("5-_4");
    @(posedge CLK);
    #1;
    check("mid reset hold", {an, seg, scanStart}, {4'hF, 8'hFF, 1'b0});
    RESET_N = 1'b1;
    do_scan(32'h92BFF799, -1, 32'd0, -1, DC);

`ifdef SEG_BRIGHTNESS_EN
    // Half duty then full duty
    brightness = 4'd7;
    set_chars("1234");
    do_scan(32'hF9A4B099, -1, 32'd0, -1, 8);
    brightness = 4'd15;
    do_scan(32'hF9A4B099, -1, 32'd0, -1, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
